// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared definitions for the BRAM-backed FWFT FIFO controller.
//   MEM_SIZE / XLEN_DEF : default geometry (log2 entries, data width)
//   DEPTH, PTR_W, CNT_W : derived sizes for the default geometry
//   next_count()        : occupancy update for one clock
package bram_fifo_ctrl_pkg;

  localparam int unsigned MEM_SIZE = 6;
  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned DEPTH    = 1 << MEM_SIZE;
  localparam int unsigned PTR_W    = MEM_SIZE;
  localparam int unsigned CNT_W    = MEM_SIZE + 1;

  // A write into memory and a read out of it in the same cycle cancel.
  // Callers guarantee inc is never set at DEPTH and dec never at 0.
  function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                             input logic        inc,
                                             input logic        dec);
    logic [31:0] res;
    case ({inc, dec})
      2'b10:   res = cnt + 32'd1;
      2'b01:   res = cnt - 32'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bram_dual_re.sv
// Simple dual-port block RAM with registered read and read enable.
//   clk_i   : clock
//   write_i : write strobe, stores data_i at waddr_i
//   read_i  : read strobe, loads data_o from raddr_i; data_o holds otherwise
//   waddr_i / raddr_i : write / read addresses
//   data_i  : write data
//   data_o  : registered read data
module bram_dual_re
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned memSize_p = MEM_SIZE,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic                 clk_i,
  input  logic                 write_i,
  input  logic                 read_i,
  input  logic [memSize_p-1:0] waddr_i,
  input  logic [memSize_p-1:0] raddr_i,
  input  logic [XLEN-1:0]      data_i,
  output logic [XLEN-1:0]      data_o
);

  logic [XLEN-1:0] mem_reg [0:(1<<memSize_p)-1];
  logic [XLEN-1:0] rdata_reg;

  always_ff @(posedge clk_i) begin
    if (write_i) begin
      mem_reg[waddr_i] <= data_i;
    end
    if (read_i) begin
      // Same-address collision returns the incoming word (write-through),
      // which lets the FIFO bypass an empty memory in one cycle.
      if (write_i && (waddr_i == raddr_i)) begin
        rdata_reg <= data_i;
      end else begin
        rdata_reg <= mem_reg[raddr_i];
      end
    end
  end

  assign data_o = rdata_reg;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one bram_dual_re.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i/data_i : write request and data; dropped while full_o
//   pop_i         : consume the head shown on data_o
//   data_o/valid_o: head entry and its valid flag (output slot)
//   full_o        : memory holds DEPTH entries
//   count_o       : entries in memory, output slot excluded
//   overflow_o    : sticky, push seen while full
//   underflow_o   : sticky, pop seen while empty
// The RAM output register doubles as the output slot, so total capacity
// is DEPTH+1.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned memSize_p = MEM_SIZE,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [XLEN-1:0]      data_i,
  output logic                 full_o,
  input  logic                 pop_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 valid_o,
  output logic [memSize_p:0]   count_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned DEPTH_L = 1 << memSize_p;
  localparam int unsigned CNT_W_L = memSize_p + 1;

  logic [memSize_p-1:0] wptr_reg, rptr_reg;
  logic [CNT_W_L-1:0]   count_reg, count_next;
  logic                 valid_reg, valid_next;
  logic                 overflow_reg, underflow_reg;
  logic                 push_acc, pop_acc, fetch;

  assign full_o   = (count_reg == CNT_W_L'(DEPTH_L));
  assign push_acc = push_i & ~full_o;
  assign pop_acc  = pop_i & valid_reg;
  // Refill the output slot whenever it is free or being vacated and
  // something is available, either in memory or arriving this cycle.
  assign fetch    = (~valid_reg | pop_i) & ((count_reg != '0) | push_acc);

  assign count_next = CNT_W_L'(next_count(32'(count_reg), push_acc, fetch));

  always_comb begin
    valid_next = valid_reg;
    if (fetch) begin
      valid_next = 1'b1;
    end else if (pop_acc) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_acc) wptr_reg <= wptr_reg + 1'b1;
      if (fetch)    rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_next;
      valid_reg <= valid_next;
      if (push_i && full_o)     overflow_reg  <= 1'b1;
      if (pop_i && !valid_reg)  underflow_reg <= 1'b1;
    end
  end

  bram_dual_re #(
    .memSize_p (memSize_p),
    .XLEN      (XLEN)
  ) u_ram (
    .clk_i   (clk_i),
    .write_i (push_acc),
    .read_i  (fetch),
    .waddr_i (wptr_reg),
    .raddr_i (rptr_reg),
    .data_i  (data_i),
    .data_o  (data_o)
  );

  assign valid_o     = valid_reg;
  assign count_o     = count_reg;
  assign overflow_o  = overflow_reg;
  assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;

  localparam int MS = 6;
  localparam int XL = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          push_i = 1'b0;
  logic [XL-1:0] data_i = '0;
  logic          pop_i = 1'b0;
  logic          full_o, valid_o, overflow_o, underflow_o;
  logic [XL-1:0] data_o;
  logic [MS:0]   count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bram_fifo_ctrl #(.memSize_p(MS), .XLEN(XL)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .data_i      (data_i),
    .full_o      (full_o),
    .pop_i       (pop_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic push, input logic [XL-1:0] d, input logic pop);
    push_i = push;
    data_i = d;
    pop_i  = pop;
    @(posedge clk_i);
    #1;
    cyc++;
    $display("[TB] cyc %0d push=%0b data_i=0x%0h pop=%0b -> valid=%0b data_o=0x%0h count=%0d full=%0b ovf=%0b unf=%0b",
             cyc, push, d, pop, valid_o, data_o, count_o, full_o, overflow_o, underflow_o);
    push_i = 1'b0;
    pop_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle(1'b0, '0, 1'b0);
    rst_i = 1'b0;
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_count", 64'(count_o), 64'd0);
    check_eq("rst_full",  64'(full_o), 64'd0);
    check_eq("rst_ovf",   64'(overflow_o), 64'd0);
    check_eq("rst_unf",   64'(underflow_o), 64'd0);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, XL'(i), 1'b0);
  endtask

  initial begin
    do_reset();

    // Bypass into an empty FIFO
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0);
    check_eq("byp_valid", 64'(valid_o), 64'd1);
    check_eq("byp_data",  64'(data_o), 64'hA5A5_A5A5);
    check_eq("byp_count", 64'(count_o), 64'd0);
    cycle(1'b0, '0, 1'b1);
    check_eq("byp_pop_valid", 64'(valid_o), 64'd0);

    // Fill to capacity, then overflow
    do_reset();
    fill(65);
    check_eq("full_valid", 64'(valid_o), 64'd1);
    check_eq("full_data",  64'(data_o), 64'd0);
    check_eq("full_count", 64'(count_o), 64'd64);
    check_eq("full_flag",  64'(full_o), 64'd1);
    check_eq("full_ovf0",  64'(overflow_o), 64'd0);
    cycle(1'b1, 32'd99, 1'b0);
    check_eq("ovf_flag",  64'(overflow_o), 64'd1);
    check_eq("ovf_count", 64'(count_o), 64'd64);
    check_eq("ovf_data",  64'(data_o), 64'd0);

    // Full with simultaneous push and pop, then drain the rest
    do_reset();
    fill(65);
    cycle(1'b1, 32'd99, 1'b1);
    check_eq("pp_ovf",   64'(overflow_o), 64'd1);
    check_eq("pp_count", 64'(count_o), 64'd63);
    check_eq("pp_full",  64'(full_o), 64'd0);
    for (int i = 1; i <= 64; i++) begin
      check_eq("pp_drain_valid", 64'(valid_o), 64'd1);
      check_eq("pp_drain_data",  64'(data_o), 64'(i));
      cycle(1'b0, '0, 1'b1);
    end
    check_eq("pp_empty_valid", 64'(valid_o), 64'd0);

    // Drain from full: 0..64 on consecutive cycles
    do_reset();
    fill(65);
    for (int i = 0; i <= 64; i++) begin
      check_eq("drain_valid", 64'(valid_o), 64'd1);
      check_eq("drain_data",  64'(data_o), 64'(i));
      check_eq("drain_count", 64'(count_o), 64'(i == 0 ? 64 : 64 - i));
      cycle(1'b0, '0, 1'b1);
    end
    check_eq("drain_end_valid", 64'(valid_o), 64'd0);
    check_eq("drain_end_count", 64'(count_o), 64'd0);
    check_eq("drain_end_unf",   64'(underflow_o), 64'd0);

    // Pop while empty
    cycle(1'b0, '0, 1'b1);
    check_eq("unf_flag",  64'(underflow_o), 64'd1);
    check_eq("unf_valid", 64'(valid_o), 64'd0);
    check_eq("unf_count", 64'(count_o), 64'd0);
    cycle(1'b0, '0, 1'b0);
    check_eq("unf_sticky", 64'(underflow_o), 64'd1);

    // Steady stream across pointer wrap with 10 entries in memory
    do_reset();
    fill(11);
    check_eq("strm_pre_count", 64'(count_o), 64'd10);
    for (int i = 0; i < 200; i++) begin
      check_eq("strm_data",  64'(data_o), 64'(i));
      check_eq("strm_valid", 64'(valid_o), 64'd1);
      cycle(1'b1, XL'(i + 11), 1'b1);
      check_eq("strm_count", 64'(count_o), 64'd10);
    end
    check_eq("strm_ovf", 64'(overflow_o), 64'd0);
    check_eq("strm_unf", 64'(underflow_o), 64'd0);

    // Reset mid-stream with count 10
    do_reset();
    cycle(1'b1, 32'h1234_5678, 1'b0);
    check_eq("post_rst_data",  64'(data_o), 64'h1234_5678);
    check_eq("post_rst_count", 64'(count_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
